counter_sequencer: RTL and testbench

Controller that sequences the board's 4-bit count datapath from raw push-buttons and switches. It synchronises and edge-detects the KEY inputs and generates the count tick from CLOCK_50 with an internal prescaler. It runs a start/stop/pause/load state machine and drives the count value plus status to LEDR and HEX decode logic. It sits between the board pins and the display logic, replacing free-running divided-clock counting with an enable-based, single-clock design.

---
 rtl/counter_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_counter_sequencer.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/counter_sequencer.sv
// ---------------------------------------------------------------------------
// counter_sequencer
//   Start/stop/pause/load sequencer for a WIDTH-bit up/down counter. The raw
//   push-buttons are synchronised and falling-edge detected into one-cycle
//   commands. The count advances on an internal prescaler tick, so the whole
//   block runs on a single clock.
//
// Ports
//   clk       : system clock; all state changes on the rising edge
//   rst       : asynchronous active-high reset
//   start_n   : raw active-low start button (asynchronous)
//   stop_n    : raw active-low stop/pause button (asynchronous)
//   load_n    : raw active-low load button (asynchronous)
//   dir       : 1 = count down, 0 = count up; sampled on each tick
//   load_val  : value loaded into the count
//   count     : current count value (registered)
//   running   : high while in RUN (decoded from the state register)
//   done      : high while in DONE (decoded from the state register)
//   state     : IDLE=00, RUN=01, PAUSE=10, DONE=11
// ---------------------------------------------------------------------------
module counter_sequencer #(
  parameter int WIDTH       = 4,
  parameter int TICK_CYCLES = 50000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_n,
  input  logic             stop_n,
  input  logic             load_n,
  input  logic             dir,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             running,
  output logic             done,
  output logic [1:0]       state
);

  localparam int PW = $clog2(TICK_CYCLES);
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10,
    S_DONE  = 2'b11
  } state_t;

  // Key bit order: [2]=load, [1]=stop, [0]=start
  logic [2:0]       w_keys;
  logic [2:0]       r_sync1;
  logic [2:0]       r_sync2;
  logic [2:0]       r_prev;
  logic [2:0]       w_fall;
  logic             w_start;
  logic             w_stop;
  logic             w_load;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] w_count_nxt;
  logic [PW-1:0]    r_presc;
  logic [PW-1:0]    w_presc_nxt;

  logic             w_tick;
  logic [WIDTH-1:0] w_step;
  logic [WIDTH-1:0] w_term;

  assign w_keys  = {load_n, stop_n, start_n};
  // A key is a command on the cycle its synchronised level goes 1 -> 0.
  assign w_fall  = r_prev & ~r_sync2;
  assign w_start = w_fall[0];
  assign w_stop  = w_fall[1];
  assign w_load  = w_fall[2];

  assign w_tick  = (r_state == S_RUN) && (r_presc == PRESC_MAX);
  assign w_step  = dir ? (r_count - WIDTH'(1)) : (r_count + WIDTH'(1));
  assign w_term  = dir ? {WIDTH{1'b0}} : {WIDTH{1'b1}};

  // Two-flop synchroniser plus previous-level flop; resets to released (1).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 3'b111;
      r_sync2 <= 3'b111;
      r_prev  <= 3'b111;
    end else begin
      r_sync1 <= w_keys;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  // State, count and prescaler registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_count <= {WIDTH{1'b0}};
      r_presc <= {PW{1'b0}};
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_presc <= w_presc_nxt;
    end
  end

  // Next-state logic. Coinciding commands resolve as load > stop > start; a
  // stop that is ignored in a state still masks a simultaneous start.
  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_presc_nxt = r_presc;
    case (r_state)
      S_IDLE: begin
        w_presc_nxt = {PW{1'b0}};
        if (w_load) begin
          w_count_nxt = load_val;
        end else if (w_stop) begin
          w_state_nxt = S_IDLE;
        end else if (w_start) begin
          w_state_nxt = S_RUN;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_RUN: begin
        if (w_load) begin
          w_count_nxt = load_val;
          w_state_nxt = S_IDLE;
          w_presc_nxt = {PW{1'b0}};
        end else if (w_stop) begin
          // Prescaler frozen at its current value, even on a tick cycle.
          w_state_nxt = S_PAUSE;
        end else if (w_tick) begin
          w_presc_nxt = {PW{1'b0}};
          w_count_nxt = w_step;
          if (w_step == w_term) begin
            w_state_nxt = S_DONE;
          end else begin
            w_state_nxt = S_RUN;
          end
        end else begin
          w_presc_nxt = r_presc + PW'(1);
        end
      end
      S_PAUSE: begin
        if (w_load) begin
          w_count_nxt = load_val;
          w_state_nxt = S_IDLE;
          w_presc_nxt = {PW{1'b0}};
        end else if (w_stop) begin
          w_state_nxt = S_PAUSE;
        end else if (w_start) begin
          // Resume with the held prescaler value.
          w_state_nxt = S_RUN;
        end else begin
          w_state_nxt = S_PAUSE;
        end
      end
      S_DONE: begin
        w_presc_nxt = {PW{1'b0}};
        if (w_load) begin
          w_count_nxt = load_val;
          w_state_nxt = S_IDLE;
        end else if (w_stop) begin
          w_state_nxt = S_DONE;
        end else if (w_start) begin
          w_count_nxt = load_val;
          w_state_nxt = S_RUN;
        end else begin
          w_state_nxt = S_DONE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_count_nxt = {WIDTH{1'b0}};
        w_presc_nxt = {PW{1'b0}};
      end
    endcase
  end

  assign count   = r_count;
  assign state   = r_state;
  assign running = (r_state == S_RUN);
  assign done    = (r_state == S_DONE);

endmodule

// File: tb/tb_counter_sequencer.sv
// ---------------------------------------------------------------------------
// tb_counter_sequencer
//   Directed bench for counter_sequencer with TICK_CYCLES=4. Inputs change
//   1 ns after a rising edge and outputs are sampled there too. A key held
//   low for one cycle right after edge p is acted on at edge p+3.
// ---------------------------------------------------------------------------
module tb_counter_sequencer;

  logic       clk;
  logic       rst;
  logic       start_n;
  logic       stop_n;
  logic       load_n;
  logic       dir;
  logic [3:0] load_val;
  logic [3:0] count;
  logic       running;
  logic       done;
  logic [1:0] state;

  int n_cmp;
  int n_err;

  counter_sequencer #(
    .WIDTH       (4),
    .TICK_CYCLES (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start_n  (start_n),
    .stop_n   (stop_n),
    .load_n   (load_n),
    .dir      (dir),
    .load_val (load_val),
    .count    (count),
    .running  (running),
    .done     (done),
    .state    (state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Check count, state, running and done together.
  task automatic chk_all(input string tag, input logic [3:0] c, input logic [1:0] s);
    chk({tag, ".count"}, 32'(count), 32'(c));
    chk({tag, ".state"}, 32'(state), 32'(s));
    chk({tag, ".running"}, 32'(running), 32'(s == 2'b01));
    chk({tag, ".done"}, 32'(done), 32'(s == 2'b11));
  endtask

  // m: [2]=load, [1]=stop, [0]=start. Returns just after the acting edge.
  task automatic press(input logic [2:0] m);
    load_n  = ~m[2];
    stop_n  = ~m[1];
    start_n = ~m[0];
    step(1);
    load_n  = 1'b1;
    stop_n  = 1'b1;
    start_n = 1'b1;
    step(2);
  endtask

  initial begin
    n_cmp    = 0;
    n_err    = 0;
    rst      = 1'b1;
    start_n  = 1'b1;
    stop_n   = 1'b1;
    load_n   = 1'b1;
    dir      = 1'b0;
    load_val = 4'd0;
    step(2);
    chk_all("reset", 4'd0, 2'b00);
    rst = 1'b0;
    step(3);
    chk_all("post_reset_idle", 4'd0, 2'b00);

    // Down count from 3
    dir      = 1'b1;
    load_val = 4'd3;
    press(3'b100);
    chk_all("dn_load", 4'd3, 2'b00);
    press(3'b001);
    chk_all("dn_entry", 4'd3, 2'b01);
    step(3);
    chk_all("dn_before_tick", 4'd3, 2'b01);
    step(1);
    chk_all("dn_step1", 4'd2, 2'b01);
    step(4);
    chk_all("dn_step2", 4'd1, 2'b01);
    step(4);
    chk_all("dn_done", 4'd0, 2'b11);
    step(20);
    chk_all("dn_hold", 4'd0, 2'b11);

    // Up count from 13 to terminal
    dir      = 1'b0;
    load_val = 4'd13;
    press(3'b100);
    chk_all("up_load", 4'd13, 2'b00);
    press(3'b001);
    chk_all("up_entry", 4'd13, 2'b01);
    step(4);
    chk_all("up_step1", 4'd14, 2'b01);
    step(4);
    chk_all("up_done", 4'd15, 2'b11);
    press(3'b001);
    chk_all("up_restart", 4'd13, 2'b01);

    // Stop lands on the tick edge: no step, prescaler frozen at its last value
    step(1);
    press(3'b010);
    chk_all("pause_entry", 4'd13, 2'b10);
    step(5);
    chk_all("pause_hold", 4'd13, 2'b10);
    press(3'b001);
    chk_all("resume_entry", 4'd13, 2'b01);
    step(1);
    chk_all("resume_step", 4'd14, 2'b01);

    // Load and start together in RUN: load wins
    dir      = 1'b1;
    load_val = 4'd0;
    press(3'b101);
    chk_all("simul_load", 4'd0, 2'b00);

    // Hold start low 50 cycles from count 0 counting down (entry at +3)
    start_n = 1'b0;
    for (int i = 1; i <= 50; i++) begin
      step(1);
      if (i == 3) chk_all("hold_entry", 4'd0, 2'b01);
      if (i == 7) chk_all("wrap_first_tick", 4'd15, 2'b01);
    end
    chk_all("hold_one_entry", 4'd5, 2'b01);
    start_n = 1'b1;
    begin
      int budget;
      budget = 0;
      while (state !== 2'b11 && budget < 40) begin
        step(1);
        budget++;
      end
      chk("wrap_done_budget", 32'(budget < 40), 32'd1);
      chk("wrap_done_cycles", 32'(budget), 32'd17);
    end
    chk_all("wrap_done", 4'd0, 2'b11);

    // Asynchronous reset mid-RUN with count 7
    load_val = 4'd7;
    press(3'b100);
    press(3'b001);
    step(2);
    chk_all("pre_rst_run", 4'd7, 2'b01);
    #3 rst = 1'b1;
    #1;
    chk_all("async_rst", 4'd0, 2'b00);
    step(1);
    rst = 1'b0;
    step(6);
    chk_all("rst_release_idle", 4'd0, 2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
